// File: rtl/arbitro_i2c.sv
// ============================================================================
// Module      : arbitro_i2c
// Description : Two-requester round-robin arbiter and sequencer for the I2C
//               transaction generator. Optional watchdog: I2C_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbitro_i2c #(
  parameter int IDLE_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  REQ,
  input  logic [1:0]  REQ_RNW,
  input  logic [6:0]  REQ_ADDR0,
  input  logic [6:0]  REQ_ADDR1,
  input  logic [15:0] REQ_WDATA0,
  input  logic [15:0] REQ_WDATA1,
  output logic [1:0]  GNT,
  output logic [1:0]  DONE,
  output logic        ERR,
  output logic [15:0] RDATA,
  output logic        BUSY,
  output logic        START_STB,
  output logic        RNW,
  output logic [6:0]  I2C_ADDR,
  output logic [15:0] WR_DATA,
  input  logic        SCL,
  input  logic [15:0] RD_DATA
);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_GRANT    = 3'd1;
  localparam logic [2:0] c_START    = 3'd2;
  localparam logic [2:0] c_WAIT_ACT = 3'd3;
  localparam logic [2:0] c_WAIT_END = 3'd4;
  localparam logic [2:0] c_DONE     = 3'd5;

  localparam int c_IW = $clog2(IDLE_CYCLES + 1);

  // The end-of-transaction detector needs a high run longer than an active
  // SCL high phase (2 clk) to tell them apart.
  if (IDLE_CYCLES <= 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("arbitro_i2c: IDLE_CYCLES must be > 2 and TIMEOUT_CYCLES >= 2");
  end

  logic [2:0]      r_state;
  logic [1:0]      r_gnt;
  logic            r_last;
  logic            r_rnw;
  logic [6:0]      r_addr;
  logic [15:0]     r_wdata;
  logic [15:0]     r_rdata;
  logic [c_IW-1:0] r_idle;

  logic            w_pick1;
  logic            w_rnw;
  logic [6:0]      w_addr;
  logic [15:0]     w_wdata;
  logic            w_end;

  // On contention the requester that was not served last wins.
  always_comb begin
    w_pick1 = 1'b0;
    if (REQ == 2'b10) begin
      w_pick1 = 1'b1;
    end else if (REQ == 2'b11) begin
      w_pick1 = ~r_last;
    end
    w_rnw   = w_pick1 ? REQ_RNW[1] : REQ_RNW[0];
    w_addr  = w_pick1 ? REQ_ADDR1  : REQ_ADDR0;
    w_wdata = w_pick1 ? REQ_WDATA1 : REQ_WDATA0;
    w_end   = (r_idle == c_IW'(IDLE_CYCLES));
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [c_TW-1:0] r_to;
  logic            r_err;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_gnt   <= 2'b00;
      r_last  <= 1'b1;
      r_rnw   <= 1'b0;
      r_addr  <= 7'd0;
      r_wdata <= 16'd0;
      r_rdata <= 16'd0;
      r_idle  <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_idle <= '0;
          if (REQ != 2'b00) begin
            r_state <= c_GRANT;
            r_gnt   <= w_pick1 ? 2'b10 : 2'b01;
            r_last  <= w_pick1;
            r_rnw   <= w_rnw;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
          end
        end
        c_GRANT:    r_state <= c_START;
        c_START:    r_state <= c_WAIT_ACT;
        c_WAIT_ACT: begin
          if (!SCL) begin
            r_state <= c_WAIT_END;
            r_idle  <= '0;
          end
        end
        c_WAIT_END: begin
          if (w_end) begin
            r_state <= c_DONE;
            if (r_rnw) begin
              r_rdata <= RD_DATA;
            end
          end else if (SCL) begin
            r_idle <= r_idle + 1'b1;
          end else begin
            r_idle <= '0;
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
          r_gnt   <= 2'b00;
          r_idle  <= '0;
        end
        default: begin
          r_state <= c_IDLE;
          r_gnt   <= 2'b00;
        end
      endcase

`ifdef I2C_ARB_TIMEOUT_EN
      // A normal end in the same cycle takes precedence over the watchdog.
      if ((r_state == c_WAIT_ACT || (r_state == c_WAIT_END && !w_end)) &&
          (r_to == c_TW'(TIMEOUT_CYCLES - 1))) begin
        r_state <= c_DONE;
      end
`endif
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to  <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == c_IDLE) begin
        r_to <= '0;
      end else if (r_state == c_START || r_state == c_WAIT_ACT ||
                   r_state == c_WAIT_END) begin
        r_to <= r_to + 1'b1;
      end
      if ((r_state == c_WAIT_ACT || (r_state == c_WAIT_END && !w_end)) &&
          (r_to == c_TW'(TIMEOUT_CYCLES - 1))) begin
        r_err <= 1'b1;
      end else if (r_state == c_DONE) begin
        r_err <= 1'b0;
      end
    end
  end

  assign ERR = r_err;
`else
  assign ERR = 1'b0;
`endif

  assign GNT       = r_gnt;
  assign DONE      = (r_state == c_DONE) ? r_gnt : 2'b00;
  assign BUSY      = (r_state != c_IDLE);
  assign START_STB = (r_state == c_START);
  assign RNW       = r_rnw;
  assign I2C_ADDR  = r_addr;
  assign WR_DATA   = r_wdata;
  assign RDATA     = r_rdata;

endmodule

`default_nettype wire
